store_write_buffer: RTL and testbench

Posted-store buffer between the write-through data cache and backing data memory in the 32-bit MIPS MEM stage. The cache hands every sw (address, data) to this block and continues without waiting. The block queues up to DEPTH stores, merges repeat stores to the same word, and drains them to memory one at a time over a request/acknowledge handshake. It also answers lw lookups so a load never reads memory data that is older than a buffered store.

---
 rtl/store_write_buffer_pkg.sv | 20 ++
 rtl/store_write_buffer_if.sv | 33 +++
 rtl/store_write_buffer_match.sv | 46 ++++
 rtl/store_write_buffer.sv | 139 +++++++++++++
 tb/tb_store_write_buffer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared types and sizing for the posted-store write buffer.
// Entry widths follow the default bus widths of the buffer.
package wbuf_pkg;

    localparam int WBUF_DEPTH  = 4;
    localparam int WBUF_ADDR_W = 32;
    localparam int WBUF_DATA_W = 32;
    localparam int PTR_W       = $clog2(WBUF_DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } wbuf_state_t;

    typedef struct packed {
        logic [WBUF_ADDR_W-1:0] addr;
        logic [WBUF_DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// Store, lookup and memory-drain signals between the cache, the buffer and memory.
interface store_write_buffer_if
    import wbuf_pkg::*;
#(
    parameter int ADDR_W = WBUF_ADDR_W,
    parameter int DATA_W = WBUF_DATA_W,
    parameter int CNT_W  = PTR_W + 1
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ack;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;

    modport master (
        output wr_req, wr_addr, wr_data, rd_addr, mem_ack,
        input  wr_ready, rd_hit, rd_data, mem_wr_en, mem_addr, mem_data, empty, full, count
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_addr, mem_ack,
        output wr_ready, rd_hit, rd_data, mem_wr_en, mem_addr, mem_data, empty, full, count
    );
endinterface

// File: rtl/store_write_buffer_match.sv
// Parallel address compare against all live entries; reports the match vector
// and the index of the youngest matching entry (nearest the tail).
module wbuf_match
    import wbuf_pkg::*;
#(
    parameter int DEPTH  = WBUF_DEPTH,
    parameter int ADDR_W = WBUF_ADDR_W,
    parameter int PW     = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
    input  logic [PW-1:0]                 head,
    input  logic [PW-1:0]                 tail,
    input  logic [PW:0]                   count,
    input  logic                          skip_head,
    output logic [DEPTH-1:0]              match_vec,
    output logic [PW-1:0]                 match_idx
);

    // Entry is live when its distance from head is below count; head optionally excluded.
    always_comb begin
        logic [PW-1:0] off_s;
        match_vec = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_s = PW'(i) - head;
            match_vec[i] = ({1'b0, off_s} < count) &&
                           !(skip_head && (PW'(i) == head)) &&
                           (entry_addr[i] == addr);
        end
    end

    // Walk from oldest to youngest slot so the last hit seen is the youngest.
    always_comb begin
        logic [PW-1:0] pos_s;
        match_idx = tail - PW'(1);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            pos_s = tail - PW'(1) - PW'(k);
            if (match_vec[pos_s]) begin
                match_idx = pos_s;
            end else begin
                match_idx = match_idx;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store buffer: circular FIFO with store merging, load forwarding and a
// two-state drain engine feeding backing memory over a req/ack handshake.
module store_write_buffer
    import wbuf_pkg::*;
#(
    parameter int DEPTH  = WBUF_DEPTH,
    parameter int ADDR_W = WBUF_ADDR_W,
    parameter int DATA_W = WBUF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    store_write_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbuf_entry_t                 entry_r [DEPTH];
    logic [PW-1:0]               head_r;
    logic [PW-1:0]               tail_r;
    logic [CW-1:0]               count_r;
    wbuf_state_t                 state_r;
    logic                        mem_wr_en_r;
    logic [ADDR_W-1:0]           mem_addr_r;
    logic [DATA_W-1:0]           mem_data_r;

    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_s;
    logic [DEPTH-1:0]            coal_vec_s;
    logic [DEPTH-1:0]            look_vec_s;
    logic [PW-1:0]               coal_idx_s;
    logic [PW-1:0]               look_idx_s;
    logic                        coal_hit_s;
    logic                        look_hit_s;
    logic                        full_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        coal_we_s;
    logic [DATA_W-1:0]           rd_data_s;

    // Flatten stored addresses for the comparators.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr_s[i] = entry_r[i].addr;
        end
    end

    // The head may already be on the memory bus, so merging skips it.
    wbuf_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PW(PW)) u_coal_match (
        .addr(bus.wr_addr), .entry_addr(entry_addr_s), .head(head_r), .tail(tail_r),
        .count(count_r), .skip_head(1'b1), .match_vec(coal_vec_s), .match_idx(coal_idx_s)
    );

    wbuf_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PW(PW)) u_look_match (
        .addr(bus.rd_addr), .entry_addr(entry_addr_s), .head(head_r), .tail(tail_r),
        .count(count_r), .skip_head(1'b0), .match_vec(look_vec_s), .match_idx(look_idx_s)
    );

    assign full_s     = (count_r == CW'(DEPTH));
    assign coal_hit_s = |coal_vec_s;
    assign look_hit_s = |look_vec_s;
    assign push_s     = bus.wr_req && !coal_hit_s && !full_s;
    assign coal_we_s  = bus.wr_req && coal_hit_s;
    assign pop_s      = (state_r == BUSY) && bus.mem_ack;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '{addr: {WBUF_ADDR_W{1'b0}}, data: {WBUF_DATA_W{1'b0}}};
            end
        end else begin
            if (push_s) begin
                entry_r[tail_r] <= '{addr: bus.wr_addr, data: bus.wr_data};
                tail_r          <= tail_r + PW'(1);
            end
            if (coal_we_s) begin
                entry_r[coal_idx_s].data <= bus.wr_data;
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Drain engine: latch head on leaving IDLE, hold until memory acknowledges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mem_wr_en_r <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_data_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (count_r != {CW{1'b0}}) begin
                        state_r     <= BUSY;
                        mem_wr_en_r <= 1'b1;
                        mem_addr_r  <= entry_r[head_r].addr;
                        mem_data_r  <= entry_r[head_r].data;
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        state_r     <= IDLE;
                        mem_wr_en_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    mem_wr_en_r <= 1'b0;
                end
            endcase
        end
    end

    // Forwarded load data, zero when nothing matches.
    always_comb begin
        if (look_hit_s) begin
            rd_data_s = entry_r[look_idx_s].data;
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    assign bus.wr_ready  = !full_s || coal_hit_s;
    assign bus.rd_hit    = look_hit_s;
    assign bus.rd_data   = rd_data_s;
    assign bus.mem_wr_en = mem_wr_en_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_data  = mem_data_r;
    assign bus.empty     = (count_r == {CW{1'b0}});
    assign bus.full      = full_s;
    assign bus.count     = count_r;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed scenarios plus randomized traffic checked against a queue-based model.
module tb_store_write_buffer;
    import wbuf_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    store_write_buffer_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bus ();

    store_write_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: FIFO as queues, plus the word currently presented to memory.
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    bit          m_busy;
    logic        m_en;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    task automatic model_edge();
        int sz;
        int ci;
        if (rst) begin
            q_addr.delete(); q_data.delete();
            m_busy = 1'b0; m_en = 1'b0; m_addr = 32'h0; m_data = 32'h0;
        end else begin
            sz = q_addr.size();
            ci = -1;
            for (int i = 1; i < sz; i++) if (q_addr[i] == bus.wr_addr) ci = i;
            if (bus.wr_req) begin
                if (ci >= 0) q_data[ci] = bus.wr_data;
                else if (sz < DEPTH) begin q_addr.push_back(bus.wr_addr); q_data.push_back(bus.wr_data); end
            end
            if (!m_busy) begin
                if (sz != 0) begin m_busy = 1'b1; m_en = 1'b1; m_addr = q_addr[0]; m_data = q_data[0]; end
            end else if (bus.mem_ack) begin
                m_busy = 1'b0; m_en = 1'b0;
                void'(q_addr.pop_front()); void'(q_data.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.wr_req = 1'b0; bus.wr_addr = 32'h0; bus.wr_data = 32'h0;
        bus.rd_addr = 32'h0; bus.mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_mem_wr_en got=%b exp=0", bus.mem_wr_en); end
        checks++; if ({bus.mem_addr, bus.mem_data} !== 64'h0) begin failures++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", bus.mem_addr, bus.mem_data); end
        checks++; if ({bus.rd_hit, bus.rd_data} !== 33'h0) begin failures++; $display("FAIL reset_lookup got=%b/%h exp=0/0", bus.rd_hit, bus.rd_data); end
        checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", bus.wr_ready); end
    endtask

    task automatic test_single_drain();
        do_reset();
        push(32'h100, 32'hAAAA);
        checks++; if (bus.mem_wr_en !== 1'b0 || bus.count !== 3'd1) begin failures++; $display("FAIL single_after_push got en=%b cnt=%0d exp en=0 cnt=1", bus.mem_wr_en, bus.count); end
        tick();
        checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_data !== 32'hAAAA) begin
            failures++; $display("FAIL single_issue got en=%b %h/%h exp en=1 100/aaaa", bus.mem_wr_en, bus.mem_addr, bus.mem_data); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.empty !== 1'b1 || bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL single_done got empty=%b en=%b exp 1/0", bus.empty, bus.mem_wr_en); end
    endtask

    task automatic test_fill_stall();
        do_reset();
        for (int i = 0; i < 4; i++) push(32'(i * 4), 32'(i + 1));
        bus.wr_req = 1'b1; bus.wr_addr = 32'h10; bus.wr_data = 32'h55;
        #1;
        checks++; if (bus.full !== 1'b1 || bus.wr_ready !== 1'b0) begin failures++; $display("FAIL fill_full got full=%b rdy=%b exp 1/0", bus.full, bus.wr_ready); end
        tick();
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL fill_drop got cnt=%0d exp=4", bus.count); end
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL fill_no_lookahead got rdy=%b exp=0", bus.wr_ready); end
        tick();
        bus.mem_ack = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd3 || bus.wr_ready !== 1'b1) begin failures++; $display("FAIL fill_after_ack got cnt=%0d rdy=%b exp 3/1", bus.count, bus.wr_ready); end
        tick();
        bus.wr_req = 1'b0;
        checks++; if (bus.count !== 3'd4 || bus.mem_addr !== 32'h4 || bus.mem_data !== 32'h2) begin
            failures++; $display("FAIL fill_accept got cnt=%0d %h/%h exp 4 4/2", bus.count, bus.mem_addr, bus.mem_data); end
    endtask

    task automatic test_coalesce();
        do_reset();
        push(32'h0, 32'h1);
        push(32'h4, 32'h2);
        push(32'h4, 32'h3);
        checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL coal_count got=%0d exp=2", bus.count); end
        push(32'h0, 32'h7);
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL coal_head_append got=%0d exp=3", bus.count); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_data !== 32'h1) begin failures++; $display("FAIL coal_drain0 got %h/%h exp 0/1", bus.mem_addr, bus.mem_data); end
        bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0; tick();
        checks++; if (bus.mem_addr !== 32'h4 || bus.mem_data !== 32'h3) begin failures++; $display("FAIL coal_drain1 got %h/%h exp 4/3", bus.mem_addr, bus.mem_data); end
        bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0; tick();
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_data !== 32'h7) begin failures++; $display("FAIL coal_drain2 got %h/%h exp 0/7", bus.mem_addr, bus.mem_data); end
    endtask

    task automatic test_lookup();
        do_reset();
        push(32'h8, 32'h5);
        bus.rd_addr = 32'h8; #1;
        checks++; if (bus.rd_hit !== 1'b1 || bus.rd_data !== 32'h5) begin failures++; $display("FAIL look_hit got %b/%h exp 1/5", bus.rd_hit, bus.rd_data); end
        bus.rd_addr = 32'hC; #1;
        checks++; if (bus.rd_hit !== 1'b0 || bus.rd_data !== 32'h0) begin failures++; $display("FAIL look_miss got %b/%h exp 0/0", bus.rd_hit, bus.rd_data); end
        tick();
        push(32'h8, 32'h9);
        bus.rd_addr = 32'h8; #1;
        checks++; if (bus.rd_hit !== 1'b1 || bus.rd_data !== 32'h9 || bus.count !== 3'd2) begin
            failures++; $display("FAIL look_youngest got %b/%h cnt=%0d exp 1/9 cnt=2", bus.rd_hit, bus.rd_data, bus.count); end
        checks++; if (bus.mem_addr !== 32'h8 || bus.mem_data !== 32'h5) begin failures++; $display("FAIL look_inflight got %h/%h exp 8/5", bus.mem_addr, bus.mem_data); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h20 + 32'(i * 4), 32'hA0 + 32'(i));
        bus.wr_req = 1'b1; bus.wr_addr = 32'h40; bus.wr_data = 32'h44; bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL pp_ready got=%b exp=0", bus.wr_ready); end
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL pp_count got=%0d exp=3", bus.count); end
        tick();
        bus.wr_req = 1'b0;
        checks++; if (bus.count !== 3'd4 || bus.mem_addr !== 32'h24) begin failures++; $display("FAIL pp_accept got cnt=%0d addr=%h exp 4/24", bus.count, bus.mem_addr); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 3; i++) push(32'h80 + 32'(i * 4), 32'(i + 9));
        checks++; if (bus.count !== 3'd3 || bus.mem_wr_en !== 1'b1) begin failures++; $display("FAIL rmd_pre got cnt=%0d en=%b exp 3/1", bus.count, bus.mem_wr_en); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (bus.mem_wr_en !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
            failures++; $display("FAIL rmd_post got en=%b cnt=%0d empty=%b exp 0/0/1", bus.mem_wr_en, bus.count, bus.empty); end
        bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
        checks++; if (bus.mem_wr_en !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
            failures++; $display("FAIL rmd_late_ack got en=%b cnt=%0d empty=%b exp 0/0/1", bus.mem_wr_en, bus.count, bus.empty); end
    endtask

    task automatic test_random();
        int          sz;
        bit          e_ready;
        bit          e_hit;
        logic [31:0] e_rdata;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.wr_req  = ($urandom_range(0, 9) < 6);
            bus.wr_addr = 32'($urandom_range(0, 5)) << 2;
            bus.wr_data = $urandom;
            bus.rd_addr = 32'($urandom_range(0, 6)) << 2;
            bus.mem_ack = ($urandom_range(0, 9) < 4);
            #1;
            sz = q_addr.size();
            e_ready = (sz < DEPTH);
            for (int i = 1; i < sz; i++) if (q_addr[i] == bus.wr_addr) e_ready = 1'b1;
            e_hit = 1'b0; e_rdata = 32'h0;
            for (int i = 0; i < sz; i++) if (q_addr[i] == bus.rd_addr) begin e_hit = 1'b1; e_rdata = q_data[i]; end
            checks++; if (bus.count !== 3'(sz) || bus.empty !== (sz == 0) || bus.full !== (sz == DEPTH)) begin
                failures++; $display("FAIL rnd_occupancy cyc=%0d got cnt=%0d e=%b f=%b exp cnt=%0d", cyc, bus.count, bus.empty, bus.full, sz); end
            checks++; if (bus.wr_ready !== e_ready) begin failures++; $display("FAIL rnd_wr_ready cyc=%0d got=%b exp=%b", cyc, bus.wr_ready, e_ready); end
            checks++; if (bus.rd_hit !== e_hit || bus.rd_data !== e_rdata) begin
                failures++; $display("FAIL rnd_lookup cyc=%0d got %b/%h exp %b/%h", cyc, bus.rd_hit, bus.rd_data, e_hit, e_rdata); end
            checks++; if (bus.mem_wr_en !== m_en || bus.mem_addr !== m_addr || bus.mem_data !== m_data) begin
                failures++; $display("FAIL rnd_mem cyc=%0d got %b %h/%h exp %b %h/%h", cyc, bus.mem_wr_en, bus.mem_addr, bus.mem_data, m_en, m_addr, m_data); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_drain();
        test_fill_stall();
        test_coalesce();
        test_lookup();
        test_full_push_pop();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
